ball_pos_update: RTL and testbench

BALL_POS_UPDATE -- requirements
Module: ball_pos_update

---
 rtl/pong_pkg.sv | 35 +++
 rtl/ball_axis_step.sv | 35 +++
 rtl/ball_pos_update.sv | 156 +++++++++++++++
 tb/tb_ball_pos_update.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the ball position datapath: Q8.8 fixed point, state encoding, field defaults.
// Pure declarations, no logic; no latency or flow-control implications.
package pong_pkg;

   localparam int POS_W  = 24;
   localparam int FRAC_W = 8;
   localparam int VEL_W  = 16;
   localparam int PIX_W  = POS_W - FRAC_W;

   localparam int X_MAX_DEF       = 639;
   localparam int Y_MAX_DEF       = 479;
   localparam int X_SERVE_DEF     = 320;
   localparam int Y_SERVE_DEF     = 40;
   localparam int VEL_LATENCY_DEF = 21;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_VEL,
      ST_RUN,
      ST_OUT
   } state_e;

   typedef logic signed [POS_W-1:0] fix_t;
   typedef logic signed [VEL_W-1:0] vel_t;

   function automatic fix_t pix_to_fix(input int pix);
      return fix_t'(pix) <<< FRAC_W;
   endfunction

   // Last fixed-point value still inside pixel `pix` (all fraction bits set).
   function automatic fix_t edge_fix(input int pix);
      return pix_to_fix(pix) + fix_t'((1 << FRAC_W) - 1);
   endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One-axis Q8.8 step: position + sign-extended velocity, wall under/over flags and mirrored position.
// Purely combinational, zero latency; no flow control.
module ball_axis_step
   import pong_pkg::*;
#(
   parameter int MAX_PIX = X_MAX_DEF
) (
   input  fix_t pos_i,
   input  vel_t vel_i,
   output fix_t sum_o,
   output logic under_o,
   output logic over_o,
   output fix_t refl_o
);

   localparam fix_t LIMIT = edge_fix(MAX_PIX);

   fix_t vel_ext;

   assign vel_ext = {{(POS_W - VEL_W){vel_i[VEL_W-1]}}, vel_i};
   assign sum_o   = pos_i + vel_ext;
   assign under_o = sum_o[POS_W-1];
   assign over_o  = !under_o && (sum_o > LIMIT);

   // Mirror about the wall: 0 on the low side, LIMIT on the high side.
   always_comb begin
      refl_o = sum_o;
      if (under_o) begin
         refl_o = -sum_o;
      end else if (over_o) begin
         refl_o = (LIMIT <<< 1) - sum_o;
      end
   end

endmodule

// File: rtl/ball_pos_update.sv
// Ball position integrator: per-frame Q8.8 accumulation, x bounces off the walls, y leaving the table ends play.
// Outputs update one cycle after the strobe; no backpressure, all control inputs are single-cycle pulses.
module ball_pos_update
   import pong_pkg::*;
#(
   parameter int X_MAX       = X_MAX_DEF,
   parameter int Y_MAX       = Y_MAX_DEF,
   parameter int X_SERVE     = X_SERVE_DEF,
   parameter int Y_SERVE     = Y_SERVE_DEF,
   parameter int VEL_LATENCY = VEL_LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_tick,
   input  logic                 serve,
   input  logic                 hit,
   input  logic [2*VEL_W-1:0]   vel_in,
   output logic [PIX_W-1:0]     pos_x,
   output logic [PIX_W-1:0]     pos_y,
   output logic                 pos_valid,
   output logic                 moving,
   output logic                 ball_out,
   output logic                 out_side
);

   localparam int              CNT_W    = (VEL_LATENCY > 1) ? $clog2(VEL_LATENCY) : 1;
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(VEL_LATENCY - 1);
   localparam fix_t            X_HOME   = pix_to_fix(X_SERVE);
   localparam fix_t            Y_HOME   = pix_to_fix(Y_SERVE);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   fix_t             px_q, px_d;
   fix_t             py_q, py_d;
   vel_t             vx_q, vx_d;
   vel_t             vy_q, vy_d;
   logic             pos_valid_q, pos_valid_d;
   logic             ball_out_q, ball_out_d;
   logic             out_side_q, out_side_d;

   fix_t x_sum, x_refl;
   logic x_under, x_over;
   fix_t y_sum, y_refl_unused;
   logic y_under, y_over;

   logic integrate;
   logic capture;
   logic y_exit;

   ball_axis_step #(.MAX_PIX(X_MAX)) u_step_x (
      .pos_i   (px_q),
      .vel_i   (vx_q),
      .sum_o   (x_sum),
      .under_o (x_under),
      .over_o  (x_over),
      .refl_o  (x_refl)
   );

   ball_axis_step #(.MAX_PIX(Y_MAX)) u_step_y (
      .pos_i   (py_q),
      .vel_i   (vy_q),
      .sum_o   (y_sum),
      .under_o (y_under),
      .over_o  (y_over),
      .refl_o  (y_refl_unused)
   );

   assign moving    = (state_q == ST_RUN) || (state_q == ST_WAIT_VEL);
   assign integrate = frame_tick && moving;
   assign capture   = (state_q == ST_WAIT_VEL) && (cnt_q == '0) && !hit;
   assign y_exit    = integrate && (y_under || y_over);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      px_d        = px_q;
      py_d        = py_q;
      vx_d        = vx_q;
      vy_d        = vy_q;
      pos_valid_d = 1'b0;
      ball_out_d  = 1'b0;
      out_side_d  = out_side_q;

      if (serve) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         px_d    = X_HOME;
         py_d    = Y_HOME;
         vx_d    = '0;
         vy_d    = '0;
      end else begin
         if ((state_q == ST_WAIT_VEL) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end

         // Integration always uses the velocity held before this cycle.
         if (integrate) begin
            px_d        = x_refl;
            py_d        = y_sum;
            pos_valid_d = 1'b1;
            if (x_under || x_over) begin
               vx_d = -vx_q;
            end
         end

         // A fresh capture wins over the bounce negation above.
         if (capture) begin
            vx_d    = vel_t'(vel_in[2*VEL_W-1:VEL_W]);
            vy_d    = vel_t'(vel_in[VEL_W-1:0]);
            state_d = ST_RUN;
         end

         if (hit && (state_q != ST_OUT)) begin
            state_d = ST_WAIT_VEL;
            cnt_d   = LAT_LOAD;
         end

         if (y_exit) begin
            state_d    = ST_OUT;
            ball_out_d = 1'b1;
            out_side_d = y_over;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         px_q        <= X_HOME;
         py_q        <= Y_HOME;
         vx_q        <= '0;
         vy_q        <= '0;
         pos_valid_q <= 1'b0;
         ball_out_q  <= 1'b0;
         out_side_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         px_q        <= px_d;
         py_q        <= py_d;
         vx_q        <= vx_d;
         vy_q        <= vy_d;
         pos_valid_q <= pos_valid_d;
         ball_out_q  <= ball_out_d;
         out_side_q  <= out_side_d;
      end
   end

   assign pos_x     = px_q[POS_W-1:FRAC_W];
   assign pos_y     = py_q[POS_W-1:FRAC_W];
   assign pos_valid = pos_valid_q;
   assign ball_out  = ball_out_q;
   assign out_side  = out_side_q;

endmodule

// File: tb/tb_ball_pos_update.sv
// Directed bench for ball_pos_update: Q8.8 reference model feeds a scoreboard popped on every pos_valid.
// Velocity capture timing is probed by presenting the real vel_in only on the expected capture edge.
module tb_ball_pos_update;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic        serve;
   logic        hit;
   logic [31:0] vel_in;
   logic [15:0] pos_x;
   logic [15:0] pos_y;
   logic        pos_valid;
   logic        moving;
   logic        ball_out;
   logic        out_side;

   ball_pos_update dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .serve      (serve),
      .hit        (hit),
      .vel_in     (vel_in),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pos_valid  (pos_valid),
      .moving     (moving),
      .ball_out   (ball_out),
      .out_side   (out_side)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        bo;
      logic        os;
   } exp_t;

   localparam int XL = 639 * 256 + 255;
   localparam int YL = 479 * 256 + 255;

   exp_t sb[$];
   int   tests  = 0;
   int   fails  = 0;
   int   pv_cnt = 0;
   int   pv_snap;
   int   mx, my, mvx, mvy;
   bit   mrun;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_serve();
      mx   = 320 * 256;
      my   = 40 * 256;
      mvx  = 0;
      mvy  = 0;
      mrun = 1'b0;
   endtask

   task automatic m_frame();
      int   nx, ny;
      exp_t e;
      if (!mrun) return;
      nx = mx + mvx;
      if (nx < 0) begin
         nx  = -nx;
         mvx = -mvx;
      end else if (nx > XL) begin
         nx  = 2 * XL - nx;
         mvx = -mvx;
      end
      ny   = my + mvy;
      e.bo = (ny < 0) || (ny > YL);
      e.os = (ny > YL);
      if (e.bo) mrun = 1'b0;
      mx  = nx;
      my  = ny;
      e.x = 16'(nx >>> 8);
      e.y = 16'(ny >>> 8);
      sb.push_back(e);
   endtask

   task automatic do_frame();
      m_frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
   endtask

   task automatic do_serve();
      serve = 1'b1;
      tick();
      serve = 1'b0;
      m_serve();
   endtask

   // Hit (optionally with a coincident frame), then offer v only on the 21st edge after the hit.
   task automatic do_hit(input logic [31:0] v, input bit with_frame);
      if (with_frame) m_frame();
      hit        = 1'b1;
      frame_tick = with_frame;
      tick();
      hit        = 1'b0;
      frame_tick = 1'b0;
      mrun       = 1'b1;
      @(negedge clk);
      chk("moving_wait", {31'd0, moving}, 32'd1);
      vel_in = ~v;
      repeat (20) tick();
      vel_in = v;
      tick();
      vel_in = ~v;
      mvx = int'($signed(v[31:16]));
      mvy = int'($signed(v[15:0]));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && pos_valid) begin
         pv_cnt++;
         tests++;
         assert (sb.size() != 0)
         else begin
            fails++;
            $error("FAIL pos_valid_unexpected: observed pulse expected none");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_pos_x", {16'd0, pos_x}, {16'd0, e.x});
            chk("sb_pos_y", {16'd0, pos_y}, {16'd0, e.y});
            chk("sb_ball_out", {31'd0, ball_out}, {31'd0, e.bo});
            if (e.bo) chk("sb_out_side", {31'd0, out_side}, {31'd0, e.os});
         end
      end
   end

   initial begin
      rst        = 1'b1;
      frame_tick = 1'b0;
      serve      = 1'b0;
      hit        = 1'b0;
      vel_in     = '0;
      m_serve();
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_pos_x", {16'd0, pos_x}, 32'd320);
      chk("rst_pos_y", {16'd0, pos_y}, 32'd40);
      chk("rst_pos_valid", {31'd0, pos_valid}, 32'd0);
      chk("rst_moving", {31'd0, moving}, 32'd0);
      chk("rst_ball_out", {31'd0, ball_out}, 32'd0);
      chk("rst_out_side", {31'd0, out_side}, 32'd0);

      do_frame();
      do_serve();
      @(negedge clk);
      chk("serve_pos_x", {16'd0, pos_x}, 32'd320);
      chk("serve_pos_y", {16'd0, pos_y}, 32'd40);
      chk("serve_moving", {31'd0, moving}, 32'd0);
      chk("idle_no_valid", pv_cnt, 32'd0);

      // Basic run: vx=1.0, vy=2.0, ten frames
      do_hit(32'h0100_0200, 1'b0);
      pv_snap = pv_cnt;
      repeat (10) do_frame();
      @(negedge clk);
      chk("run_pos_x", {16'd0, pos_x}, 32'd330);
      chk("run_pos_y", {16'd0, pos_y}, 32'd60);
      chk("run_valid_cnt", pv_cnt - pv_snap, 32'd10);
      chk("run_moving", {31'd0, moving}, 32'd1);

      // Right wall at 638.0 with vx=2.0; the hit lands together with the frame reaching 638
      do_serve();
      do_hit(32'h6A00_0000, 1'b0);
      repeat (2) do_frame();
      do_hit(32'h0200_0000, 1'b1);
      do_frame();
      @(negedge clk);
      chk("refl_r_pos_x", {16'd0, pos_x}, 32'd639);
      do_frame();
      @(negedge clk);
      chk("refl_r_next_x", {16'd0, pos_x}, 32'd637);

      // Left wall then right wall with |vx| = 106.0
      do_serve();
      do_hit(32'h9600_0000, 1'b0);
      repeat (4) do_frame();
      @(negedge clk);
      chk("refl_l_pos_x", {16'd0, pos_x}, 32'd104);
      repeat (6) do_frame();
      @(negedge clk);
      chk("refl_r2_pos_x", {16'd0, pos_x}, 32'd539);

      // Exit through the near edge: y=1.0, vy=-2.0
      do_serve();
      do_hit(32'h0000_F300, 1'b0);
      repeat (3) do_frame();
      do_hit(32'h0000_FE00, 1'b0);
      do_frame();
      @(negedge clk);
      chk("out_lo_moving", {31'd0, moving}, 32'd0);
      chk("out_lo_pos_y", {16'd0, pos_y}, 32'h0000_FFFF);
      chk("out_lo_side", {31'd0, out_side}, 32'd0);
      chk("out_lo_pulse_end", {31'd0, ball_out}, 32'd0);
      hit = 1'b1;
      tick();
      hit = 1'b0;
      repeat (25) tick();
      @(negedge clk);
      chk("out_hit_ignored", {31'd0, moving}, 32'd0);
      do_frame();
      @(negedge clk);
      chk("out_frozen_y", {16'd0, pos_y}, 32'h0000_FFFF);
      do_serve();
      @(negedge clk);
      chk("reserve_pos_x", {16'd0, pos_x}, 32'd320);
      chk("reserve_pos_y", {16'd0, pos_y}, 32'd40);
      chk("reserve_moving", {31'd0, moving}, 32'd0);

      // Exit through the far edge: vy=127.0
      do_hit(32'h0000_7F00, 1'b0);
      repeat (4) do_frame();
      repeat (3) tick();
      @(negedge clk);
      chk("out_hi_side_held", {31'd0, out_side}, 32'd1);
      chk("out_hi_moving", {31'd0, moving}, 32'd0);

      // Second hit 5 cycles after the first restarts the capture window
      do_serve();
      hit = 1'b1;
      tick();
      hit    = 1'b0;
      mrun   = 1'b1;
      vel_in = 32'h0300_0000;
      repeat (4) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      repeat (20) tick();
      vel_in = 32'h0100_0000;
      tick();
      vel_in = 32'h0700_0000;
      mvx = 256;
      mvy = 0;
      do_frame();
      @(negedge clk);
      chk("dbl_hit_pos_x", {16'd0, pos_x}, 32'd321);

      // Reset 10 cycles into WAIT_VEL
      hit = 1'b1;
      tick();
      hit    = 1'b0;
      vel_in = 32'h0500_0000;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_serve();
      @(negedge clk);
      chk("rstw_pos_x", {16'd0, pos_x}, 32'd320);
      chk("rstw_pos_y", {16'd0, pos_y}, 32'd40);
      chk("rstw_moving", {31'd0, moving}, 32'd0);
      chk("rstw_out_side", {31'd0, out_side}, 32'd0);
      chk("rstw_pos_valid", {31'd0, pos_valid}, 32'd0);
      repeat (15) tick();
      @(negedge clk);
      chk("rstw_no_capture", {31'd0, moving}, 32'd0);
      do_frame();
      @(negedge clk);
      chk("rstw_pos_x_late", {16'd0, pos_x}, 32'd320);

      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
